// File: rtl/denise_pkg.sv
// Shared definitions for the Denise colour table write path.
//  - Custom register decode constants for COLOR00..COLOR31 (0x180-0x1BE).
//  - Bit offsets of the fields inside the 32-bit colour RAM word.
//  - Byte-enable patterns for full and low-nibble-only writes.
//  - Output source selector shared by the commit mux.
//  - pack_color(): builds the RAM word from a 12-bit RGB value.
package denise_pkg;

  // Register address bits [8:1]; a hit needs [7:5] == 3'b110.
  localparam logic [7:0] COLOR_REG_BASE = 8'hC0;
  localparam logic [7:0] COLOR_REG_MASK = 8'hE0;

  // Word layout: bytes 0-1 hold the high nibbles, bytes 2-3 the low
  // nibbles plus the genlock bit.
  localparam int RG_HI_LSB = 0;
  localparam int B_HI_LSB  = 12;
  localparam int RG_LO_LSB = 16;
  localparam int GL_BIT    = 24;
  localparam int B_LO_LSB  = 28;

  localparam logic [3:0] BYTEENA_FULL = 4'b1111;
  localparam logic [3:0] BYTEENA_LOW  = 4'b1100;

  typedef enum logic [1:0] {
    SRC_HOLD  = 2'd0,
    SRC_SWEEP = 2'd1,
    SRC_QUEUE = 2'd2
  } out_src_e;

  // rgb = {R,G,B}. With lo_only set only bytes 2-3 carry data and bytes
  // 0-1 are driven zero (they are masked off by the byte enables).
  function automatic logic [31:0] pack_color(input logic [11:0] rgb,
                                             input logic        gl,
                                             input logic        lo_only);
    logic [31:0] word;
    word = '0;
    word[RG_LO_LSB +: 8] = rgb[11:4];
    word[B_LO_LSB  +: 4] = rgb[3:0];
    word[GL_BIT]         = gl;
    if (!lo_only) begin
      word[RG_HI_LSB +: 8] = rgb[11:4];
      word[B_HI_LSB  +: 4] = rgb[3:0];
    end
    return word;
  endfunction

endpackage

// File: rtl/denise_ct_wfifo.sv
// Synchronous FIFO holding pending colour table writes.
// Ports:
//  clock, reset_n      clock / asynchronous active-low reset (flushes queue)
//  push, push_data     enqueue request and entry
//  pop                 dequeue request (ignored when empty)
//  full, empty         occupancy flags
//  head                oldest entry, valid whenever empty==0
// A push while full is accepted only when a pop happens on the same edge.
module denise_ct_wfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 44
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/denise_colortable_writer.sv
// Write side of the Denise colour table RAM.
// Decodes COLOR00..COLOR31 register writes, applies the AGA bank / LOCT
// selection, packs each value into a 32-bit RAM word with byte enables and
// queues it until the RAM's shared enable lets it commit. After reset (and
// on init_start) the whole table is swept to zero before queued writes go.
// Ports:
//  clock, reset_n          clock / asynchronous active-low reset
//  reg_strobe              qualified custom register write
//  reg_address_in          register address bits [8:1]
//  data_in                 register write data
//  aga, bank, loct         chipset mode, BPLCON3[15:13], BPLCON3[9]
//  init_start              restart the clear sweep and clear overflow
//  ram_enable              RAM shared enable; commits happen only when high
//  wren, wraddress, data,
//  byteena_a               RAM write port
//  busy                    sweep active or writes pending
//  overflow                sticky: a colour write was dropped
module denise_colortable_writer
  import denise_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int ADDR_W        = 8,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              reg_strobe,
  input  logic [7:0]        reg_address_in,
  input  logic [15:0]       data_in,
  input  logic              aga,
  input  logic [2:0]        bank,
  input  logic              loct,
  input  logic              init_start,
  input  logic              ram_enable,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic [31:0]       data,
  output logic [3:0]        byteena_a,
  output logic              busy,
  output logic              overflow
);

  localparam int ENTRY_W = ADDR_W + 32 + 4;
  localparam logic SWEEP_AT_RESET = (INIT_ON_RESET != 0);

  logic               hit;
  logic               lo_only;
  logic [7:0]         color_addr;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] head;
  logic               q_full;
  logic               q_empty;
  logic               pop;
  logic               sweep_commit;
  logic               unused_bits;

  // armed stays low until the first edge after reset release, so no write
  // is ever presented while reset is (or has just been) asserted.
  logic               armed;
  logic               sweep_active;
  logic [ADDR_W-1:0]  sweep_count;
  logic [ADDR_W-1:0]  last_addr;
  logic [31:0]        last_data;
  logic [3:0]         last_be;

  out_src_e           src;
  logic [ADDR_W-1:0]  out_addr;
  logic [31:0]        out_data;
  logic [3:0]         out_be;

  // Decode and pack
  assign hit        = reg_strobe &&
                      ((reg_address_in & COLOR_REG_MASK) == COLOR_REG_BASE);
  assign lo_only    = aga && loct;
  assign color_addr = {(aga ? bank : 3'b000), reg_address_in[4:0]};
  assign entry      = {ADDR_W'(color_addr),
                       pack_color(data_in[11:0], data_in[15], lo_only),
                       (lo_only ? BYTEENA_LOW : BYTEENA_FULL)};
  assign unused_bits = ^data_in[14:12];

  denise_ct_wfifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wfifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (hit),
    .push_data (entry),
    .pop       (pop),
    .full      (q_full),
    .empty     (q_empty),
    .head      (head)
  );

  // Output source: the sweep has priority over queued register writes.
  always_comb begin
    src      = SRC_HOLD;
    out_addr = last_addr;
    out_data = last_data;
    out_be   = last_be;
    if (armed) begin
      if (sweep_active)  src = SRC_SWEEP;
      else if (!q_empty) src = SRC_QUEUE;
    end
    case (src)
      SRC_SWEEP: begin
        out_addr = sweep_count;
        out_data = '0;
        out_be   = BYTEENA_FULL;
      end
      SRC_QUEUE: {out_addr, out_data, out_be} = head;
      default: ;
    endcase
  end

  assign wren         = ram_enable && (src != SRC_HOLD);
  assign pop          = ram_enable && (src == SRC_QUEUE);
  assign sweep_commit = ram_enable && (src == SRC_SWEEP);
  assign wraddress    = out_addr;
  assign data         = out_data;
  assign byteena_a    = out_be;
  assign busy         = sweep_active || !q_empty;

  // Sweep counter, overflow flag and held output values
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed        <= 1'b0;
      sweep_active <= SWEEP_AT_RESET;
      sweep_count  <= '0;
      overflow     <= 1'b0;
      last_addr    <= '0;
      last_data    <= '0;
      last_be      <= '0;
    end else begin
      armed <= 1'b1;

      if (init_start) begin
        sweep_active <= 1'b1;
        sweep_count  <= '0;
      end else if (sweep_commit) begin
        sweep_count <= sweep_count + 1'b1;
        if (sweep_count == '1) sweep_active <= 1'b0;
      end

      // A drop in the same cycle as init_start still raises the flag.
      if (hit && q_full && !pop) overflow <= 1'b1;
      else if (init_start)       overflow <= 1'b0;

      if (wren) begin
        last_addr <= out_addr;
        last_data <= out_data;
        last_be   <= out_be;
      end
    end
  end

endmodule
